// File: rtl/control_fsm.sv
// Multi-cycle LEGv8 control sequencer: decodes instruction[31:21] and walks the datapath through
// FETCH/DECODE/EXEC/MEM/WB/BR, trapping on illegal opcodes or memory timeouts. Optional: CTRL_PERF_EN.
module control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        Z,
  input  logic        mem_ready,
  output logic        rstPC,
  output logic        wPC,
  output logic        ir_load,
  output logic        regMux_selector,
  output logic        wRegbank,
  output logic        aluMUX_selector,
  output logic [3:0]  opAlu,
  output logic        jumpMUX_selector,
  output logic        readMem,
  output logic        writeMem,
  output logic        Mem_selector,
  output logic        illegal,
`ifdef CTRL_PERF_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] retired_cnt,
`endif
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BR, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ, OP_B
  } op_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  op_t        op_q, op_d, dec_op, cur_op;
  logic       dec_ok;
  logic [7:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;
  logic       sel_active;
  logic       unused_fields;

  assign unused_fields = ^instruction[20:0];

  always_comb begin
    dec_ok = 1'b1;
    dec_op = OP_ADD;
    if      (instruction[31:21] == 11'b10001011000) dec_op = OP_ADD;
    else if (instruction[31:21] == 11'b11001011000) dec_op = OP_SUB;
    else if (instruction[31:21] == 11'b10001010000) dec_op = OP_AND;
    else if (instruction[31:21] == 11'b10101010000) dec_op = OP_ORR;
    else if (instruction[31:21] == 11'b11111000010) dec_op = OP_LDUR;
    else if (instruction[31:21] == 11'b11111000000) dec_op = OP_STUR;
    else if (instruction[31:24] == 8'b10110100)     dec_op = OP_CBZ;
    else if (instruction[31:26] == 6'b000101)       dec_op = OP_B;
    else                                            dec_ok = 1'b0;
  end

  // The instruction word is only trusted during DECODE; later states use the latched class.
  assign cur_op = (state_q == S_DECODE) ? dec_op : op_q;
  assign op_d   = (state_q == S_DECODE) ? dec_op : op_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = 8'd0;
    unique case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (!dec_ok)              state_d = S_TRAP;
        else if (dec_op == OP_B)  state_d = S_BR;
        else                      state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op_q == OP_LDUR || op_q == OP_STUR) state_d = S_MEM;
        else if (op_q == OP_CBZ)                state_d = S_BR;
        else                                    state_d = S_WB;
      end
      S_MEM: begin
        // mem_ready in the last allowed cycle still completes the access
        if (mem_ready)                  state_d = (op_q == OP_LDUR) ? S_WB : S_FETCH;
        else if (cnt_q == TIMEOUT_LAST) state_d = S_TRAP;
        else                            cnt_d   = cnt_q + 8'd1;
      end
      S_WB:     state_d = S_FETCH;
      S_BR:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_RST;
    endcase
    if (rst) begin
      state_d = S_RST;
      cnt_d   = 8'd0;
    end
  end

  assign illegal_d = (state_d == S_TRAP) || (illegal_q && !rst);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RST;
      op_q      <= OP_ADD;
      cnt_q     <= 8'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    sel_active       = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB) ||
                       (state_q == S_BR) || (state_q == S_DECODE && dec_ok);
    rstPC            = (state_q == S_RST);
    ir_load          = (state_q == S_FETCH);
    regMux_selector  = sel_active && (cur_op == OP_CBZ || cur_op == OP_STUR);
    aluMUX_selector  = sel_active && (cur_op == OP_LDUR || cur_op == OP_STUR);
    Mem_selector     = sel_active && (cur_op == OP_LDUR);
    opAlu            = 4'b0000;
    if (sel_active) begin
      unique case (cur_op)
        OP_SUB:           opAlu = 4'b0110;
        OP_AND, OP_B:     opAlu = 4'b0000;
        OP_ORR:           opAlu = 4'b0001;
        OP_CBZ:           opAlu = 4'b0111;
        default:          opAlu = 4'b0010;
      endcase
    end
    jumpMUX_selector = (state_q == S_BR) && (op_q == OP_B || (op_q == OP_CBZ && Z));
    readMem          = (state_q == S_MEM) && (op_q == OP_LDUR);
    writeMem         = (state_q == S_MEM) && (op_q == OP_STUR);
    // A reset arriving mid-instruction must not let the instruction retire.
    wRegbank         = !rst && (state_q == S_WB);
    wPC              = !rst && ((state_q == S_WB) || (state_q == S_BR) ||
                                (writeMem && mem_ready));
    illegal          = illegal_q;
    state_dbg        = state_q;
  end

`ifdef CTRL_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d, retired_cnt_q, retired_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + ((state_q != S_RST) ? 32'd1 : 32'd0);
    retired_cnt_d = retired_cnt_q + (wPC ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= 32'd0;
      retired_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: per-instruction transactions judged against
// latency/pulse-count expectations derived from the instruction class.
module tb_control_fsm;
  localparam int MEM_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = 32'd0;
  logic        Z = 1'b0;
  logic        mem_ready = 1'b0;
  logic        rstPC, wPC, ir_load, regMux_selector, wRegbank, aluMUX_selector;
  logic [3:0]  opAlu;
  logic        jumpMUX_selector, readMem, writeMem, Mem_selector, illegal;
  logic [2:0]  state_dbg;
`ifdef CTRL_PERF_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  control_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .Z(Z), .mem_ready(mem_ready),
    .rstPC(rstPC), .wPC(wPC), .ir_load(ir_load), .regMux_selector(regMux_selector),
    .wRegbank(wRegbank), .aluMUX_selector(aluMUX_selector), .opAlu(opAlu),
    .jumpMUX_selector(jumpMUX_selector), .readMem(readMem), .writeMem(writeMem),
    .Mem_selector(Mem_selector), .illegal(illegal),
`ifdef CTRL_PERF_EN
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // instruction classes: 0 ADD,1 SUB,2 AND,3 ORR,4 LDUR,5 STUR,6 CBZ,7 B,8 illegal
  function automatic int classify(input logic [31:0] w);
    if (w[31:21] == 11'b10001011000) return 0;
    if (w[31:21] == 11'b11001011000) return 1;
    if (w[31:21] == 11'b10001010000) return 2;
    if (w[31:21] == 11'b10101010000) return 3;
    if (w[31:21] == 11'b11111000010) return 4;
    if (w[31:21] == 11'b11111000000) return 5;
    if (w[31:24] == 8'b10110100)     return 6;
    if (w[31:26] == 6'b000101)       return 7;
    return 8;
  endfunction

  function automatic logic [31:0] make_word(input int cls);
    logic [31:0] w;
    logic [10:0] opc;
    w = $urandom;
    case (cls)
      0: opc = 11'b10001011000;
      1: opc = 11'b11001011000;
      2: opc = 11'b10001010000;
      3: opc = 11'b10101010000;
      4: opc = 11'b11111000010;
      default: opc = 11'b11111000000;
    endcase
    if (cls <= 5)      w[31:21] = opc;
    else if (cls == 6) w[31:24] = 8'b10110100;
    else if (cls == 7) w[31:26] = 6'b000101;
    else while (classify(w) != 8) w = $urandom;
    return w;
  endfunction

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Runs one instruction starting in a FETCH cycle; d = cycles mem_ready is withheld in MEM.
  task automatic run_instr(input logic [31:0] word, input int d, input logic z, input string tag);
    int cls, exp_len, exp_rd, exp_wr, exp_wreg;
    logic [3:0] exp_op;
    logic exp_jmp, exp_msel, exp_trap;
    int waits = 0, rd = 0, wr = 0, wreg = 0, wpc = 0, len = 0, trap_k = -1;
    logic [3:0] op2 = 4'hx;
    logic jmp = 1'b0, msel = 1'b0, both = 1'b0, trapped = 1'b0;

    cls = classify(word);
    case (cls)
      0, 1, 2, 3: exp_len = 4;
      4:          exp_len = 5 + d;
      5:          exp_len = 4 + d;
      6:          exp_len = 4;
      7:          exp_len = 3;
      default:    exp_len = 0;
    endcase
    case (cls)
      0:       exp_op = 4'b0010;
      1:       exp_op = 4'b0110;
      2:       exp_op = 4'b0000;
      3:       exp_op = 4'b0001;
      6:       exp_op = 4'b0111;
      default: exp_op = 4'b0010;
    endcase
    exp_wreg = (cls <= 4) ? 1 : 0;
    exp_rd   = (cls == 4) ? d + 1 : 0;
    exp_wr   = (cls == 5) ? d + 1 : 0;
    exp_jmp  = (cls == 7) || (cls == 6 && z);
    exp_msel = (cls == 4);
    exp_trap = (cls == 8);

    instruction = word;
    Z = z;
    for (int k = 0; k < 60; k++) begin
      if (readMem || writeMem) begin
        mem_ready = (waits == d);
        waits++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (readMem) rd++;
      if (writeMem) wr++;
      if (wRegbank) wreg++;
      if (wRegbank && writeMem) both = 1'b1;
      if (k == 2) op2 = opAlu;
      if (illegal && !trapped) begin trapped = 1'b1; trap_k = k; end
      if (wPC) begin
        wpc++;
        if (len == 0) begin len = k + 1; jmp = jumpMUX_selector; msel = Mem_selector; end
      end
      @(negedge clk);
      if (k >= 1) instruction = $urandom;
      if (len != 0 || trapped) break;
    end
    mem_ready = 1'b0;
    #1;

    n_checks++;
    if (trapped !== exp_trap) begin n_fail++;
      $display("FAIL %s trap: got %0b want %0b (word %h)", tag, trapped, exp_trap, word); end
    if (!exp_trap) begin
      n_checks++;
      if (len !== exp_len) begin n_fail++;
        $display("FAIL %s latency: got %0d want %0d (word %h d %0d)", tag, len, exp_len, word, d); end
      n_checks++;
      if (wpc !== 1) begin n_fail++; $display("FAIL %s wPC pulses: got %0d want 1", tag, wpc); end
      n_checks++;
      if (wreg !== exp_wreg) begin n_fail++;
        $display("FAIL %s wRegbank cycles: got %0d want %0d", tag, wreg, exp_wreg); end
      n_checks++;
      if (rd !== exp_rd || wr !== exp_wr) begin n_fail++;
        $display("FAIL %s mem req cycles: rd %0d wr %0d want rd %0d wr %0d", tag, rd, wr, exp_rd, exp_wr); end
      n_checks++;
      if (jmp !== exp_jmp) begin n_fail++;
        $display("FAIL %s jumpMUX_selector: got %0b want %0b", tag, jmp, exp_jmp); end
      n_checks++;
      if (msel !== exp_msel) begin n_fail++;
        $display("FAIL %s Mem_selector: got %0b want %0b", tag, msel, exp_msel); end
      if (cls != 7) begin
        n_checks++;
        if (op2 !== exp_op) begin n_fail++;
          $display("FAIL %s opAlu in EXEC: got %b want %b", tag, op2, exp_op); end
      end
      n_checks++;
      if (both !== 1'b0) begin n_fail++;
        $display("FAIL %s wRegbank and writeMem overlap: got 1 want 0", tag); end
      n_checks++;
      if (ir_load !== 1'b1) begin n_fail++;
        $display("FAIL %s back to FETCH: ir_load got %0b want 1", tag, ir_load); end
    end else begin
      n_checks++;
      if (trap_k !== 2 || wpc !== 0) begin n_fail++;
        $display("FAIL %s illegal trap: cycle %0d wPC %0d want cycle 2 wPC 0", tag, trap_k, wpc); end
    end
  endtask

  // scenarios
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (rstPC !== 1'b1 || {wPC, wRegbank, readMem, writeMem, ir_load, illegal} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_hold: rstPC %0b enables %b want rstPC 1 enables 000000", rstPC,
                 {wPC, wRegbank, readMem, writeMem, ir_load, illegal});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (ir_load !== 1'b1 || rstPC !== 1'b0) begin n_fail++;
      $display("FAIL reset_release: ir_load %0b rstPC %0b want 1 0", ir_load, rstPC); end
  endtask

  task automatic test_fixed();
    run_instr(32'h8B020020, 0, 1'b0, "add_fixed");
    run_instr(make_word(4), 3, 1'b0, "ldur_delay3");
    run_instr(make_word(6), 0, 1'b1, "cbz_z1");
    run_instr(make_word(6), 0, 1'b0, "cbz_z0");
    run_instr(make_word(7), 0, 1'b0, "b_plain");
    run_instr(make_word(5), 0, 1'b0, "stur_now");
  endtask

  task automatic test_mem_boundary();
    run_instr(make_word(4), MEM_TIMEOUT - 1, 1'b0, "ldur_last_cycle");
    run_instr(make_word(5), MEM_TIMEOUT - 1, 1'b0, "stur_last_cycle");
  endtask

  task automatic test_timeout();
    int wr = 0, wpc = 0, trap_k = -1;
    instruction = make_word(5);
    mem_ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (writeMem) wr++;
      if (wPC) wpc++;
      if (illegal) begin trap_k = k; break; end
      @(negedge clk);
    end
    n_checks++;
    if (wr !== MEM_TIMEOUT || trap_k !== 3 + MEM_TIMEOUT || wpc !== 0) begin n_fail++;
      $display("FAIL timeout: writeMem cycles %0d trap cycle %0d wPC %0d want %0d %0d 0",
               wr, trap_k, wpc, MEM_TIMEOUT, 3 + MEM_TIMEOUT);
    end
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (illegal !== 1'b1 || ir_load !== 1'b0 || wPC !== 1'b0) begin n_fail++;
      $display("FAIL trap_sticky: illegal %0b ir_load %0b wPC %0b want 1 0 0", illegal, ir_load, wPC); end
    do_reset();
    #1;
    n_checks++;
    if (illegal !== 1'b0 || ir_load !== 1'b1) begin n_fail++;
      $display("FAIL trap_clear: illegal %0b ir_load %0b want 0 1", illegal, ir_load); end
  endtask

  task automatic test_illegal();
    run_instr(32'hFFFFFFFF, 0, 1'b0, "illegal_ffff");
    do_reset();
  endtask

  task automatic test_reset_mid();
    instruction = make_word(4);
    mem_ready = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (readMem !== 1'b1) begin n_fail++;
      $display("FAIL mid_ldur_wait: readMem got %0b want 1", readMem); end
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (readMem !== 1'b0 || rstPC !== 1'b1) begin n_fail++;
      $display("FAIL mid_ldur_reset: readMem %0b rstPC %0b want 0 1", readMem, rstPC); end
    rst = 1'b0;
    @(negedge clk);
    instruction = make_word(0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (wPC !== 1'b0 || wRegbank !== 1'b0) begin n_fail++;
      $display("FAIL wb_reset_abort: wPC %0b wRegbank %0b want 0 0", wPC, wRegbank); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      int cls;
      cls = $urandom_range(0, 8);
      run_instr(make_word(cls), $urandom_range(0, 6), 1'($urandom_range(0, 1)), "random");
      if (cls == 8) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_mem_boundary();
    test_timeout();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
